// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, widths and helper types for the ID stage.
package mips_pkg;

  localparam int NB_REG      = 32;
  localparam int NB_INSTR    = 32;
  localparam int N_REGS      = 32;
  localparam int NB_REG_ADDR = 5;
  localparam int NB_INM_I    = 16;
  localparam int NB_INM_J    = 26;
  localparam int NB_OP       = 6;

  localparam logic [NB_OP-1:0] OP_RTYPE = 6'b000000;
  localparam logic [NB_OP-1:0] OP_J     = 6'b000010;
  localparam logic [NB_OP-1:0] OP_JAL   = 6'b000011;
  localparam logic [NB_OP-1:0] OP_BEQ   = 6'b000100;
  localparam logic [NB_OP-1:0] OP_BNE   = 6'b000101;
  localparam logic [NB_OP-1:0] OP_ANDI  = 6'b001100;
  localparam logic [NB_OP-1:0] OP_ORI   = 6'b001101;
  localparam logic [NB_OP-1:0] OP_XORI  = 6'b001110;

  localparam logic [NB_OP-1:0] FUNCT_JR   = 6'b001000;
  localparam logic [NB_OP-1:0] FUNCT_JALR = 6'b001001;

  // Link register for JAL.
  localparam logic [NB_REG_ADDR-1:0] REG_RA = 5'd31;

  // Coarse instruction class; everything not listed decodes as a NOP.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_JUMP,
    CLS_BRANCH,
    CLS_ALUI,
    CLS_LOAD,
    CLS_STORE
  } op_class_t;

  // Control bits carried through ID/EX.
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic link;
  } ctrl_t;

  function automatic op_class_t classify(input logic [NB_OP-1:0] op);
    op_class_t cls;
    cls = CLS_NOP;
    if (op == OP_RTYPE)                     cls = CLS_RTYPE;
    else if (op == OP_J || op == OP_JAL)    cls = CLS_JUMP;
    else if (op == OP_BEQ || op == OP_BNE)  cls = CLS_BRANCH;
    else if (op[5:3] == 3'b001)             cls = CLS_ALUI;
    else if (op[5:3] == 3'b100)             cls = CLS_LOAD;
    else if (op[5:3] == 3'b101)             cls = CLS_STORE;
    return cls;
  endfunction

endpackage

// File: rtl/register_file.sv
// 2-read / 1-write register file with r0 hard-wired to zero and
// write-first bypass on both read ports.
module register_file #(
  parameter int NB_REG      = 32,
  parameter int N_REGS      = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_we,
  input  logic [NB_REG_ADDR-1:0] i_waddr,
  input  logic [NB_REG-1:0]      i_wdata,
  input  logic [NB_REG_ADDR-1:0] i_raddr_a,
  input  logic [NB_REG_ADDR-1:0] i_raddr_b,
  output logic [NB_REG-1:0]      o_rdata_a,
  output logic [NB_REG-1:0]      o_rdata_b
);

  logic [NB_REG-1:0] regs_q [N_REGS];
  logic              write_en;

  assign write_en = i_we && (i_waddr != '0);

  // Storage update; every entry clears on reset.
  // NOTE: the array is reset element by element so it maps to flops; a RAM macro could not be cleared this way.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (write_en) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  // Combinational reads: r0 is zero, a same-cycle write wins over stored data.
  always_comb begin
    o_rdata_a = regs_q[i_raddr_a];
    o_rdata_b = regs_q[i_raddr_b];
    if (write_en && i_waddr == i_raddr_a) o_rdata_a = i_wdata;
    if (write_en && i_waddr == i_raddr_b) o_rdata_b = i_wdata;
    if (i_raddr_a == '0) o_rdata_a = '0;
    if (i_raddr_b == '0) o_rdata_b = '0;
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: register read, control decode, hazard detection,
// early branch/jump resolution for fetch, and the ID/EX pipeline register.
module instruction_decode #(
  parameter int NB_REG      = mips_pkg::NB_REG,
  parameter int NB_INSTR    = mips_pkg::NB_INSTR,
  parameter int N_REGS      = mips_pkg::N_REGS,
  parameter int NB_REG_ADDR = mips_pkg::NB_REG_ADDR,
  parameter int NB_INM_I    = mips_pkg::NB_INM_I,
  parameter int NB_INM_J    = mips_pkg::NB_INM_J
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_INSTR-1:0]    i_instr,
  input  logic [NB_REG-1:0]      i_pc,
  input  logic                   i_wb_we,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]      i_wb_data,
  input  logic                   i_ex_regwrite,
  input  logic                   i_ex_memread,
  input  logic [NB_REG_ADDR-1:0] i_ex_dest,
  input  logic                   i_mem_regwrite,
  input  logic [NB_REG_ADDR-1:0] i_mem_dest,
  output logic [NB_INM_I-1:0]    o_inm_i,
  output logic [NB_INM_J-1:0]    o_inm_j,
  output logic [NB_REG-1:0]      o_rs,
  output logic                   o_branch,
  output logic                   o_jump_inm,
  output logic                   o_jump_rs,
  output logic                   o_hazard,
  output logic [NB_REG-1:0]      o_rs_data,
  output logic [NB_REG-1:0]      o_rt_data,
  output logic [NB_REG-1:0]      o_inm,
  output logic [NB_REG_ADDR-1:0] o_rs_addr,
  output logic [NB_REG_ADDR-1:0] o_rt_addr,
  output logic [NB_REG_ADDR-1:0] o_rd_dest,
  output logic [5:0]             o_opcode,
  output logic [5:0]             o_funct,
  output logic [NB_REG-1:0]      o_link_addr,
  output logic                   o_regwrite,
  output logic                   o_memread,
  output logic                   o_memwrite,
  output logic                   o_memtoreg,
  output logic                   o_alusrc,
  output logic                   o_link
);

  import mips_pkg::*;

  typedef struct packed {
    logic [NB_REG-1:0]      rs_data;
    logic [NB_REG-1:0]      rt_data;
    logic [NB_REG-1:0]      inm;
    logic [NB_REG-1:0]      link_addr;
    logic [NB_REG_ADDR-1:0] rs_addr;
    logic [NB_REG_ADDR-1:0] rt_addr;
    logic [NB_REG_ADDR-1:0] rd_dest;
    logic [NB_OP-1:0]       opcode;
    logic [NB_OP-1:0]       funct;
    ctrl_t                  ctrl;
  } id_ex_t;

  logic [NB_OP-1:0]       opcode;
  logic [NB_OP-1:0]       funct;
  logic [NB_REG_ADDR-1:0] rs_addr;
  logic [NB_REG_ADDR-1:0] rt_addr;
  logic [NB_REG_ADDR-1:0] rd_addr;
  op_class_t              op_class;
  logic                   is_jump_reg;

  logic [NB_REG-1:0]      rs_val;
  logic [NB_REG-1:0]      rt_val;
  logic [NB_REG-1:0]      inm_ext;

  ctrl_t                  ctrl_d;
  logic [NB_REG_ADDR-1:0] rd_dest_d;
  logic                   reads_rt;
  logic                   early_rs;
  logic                   early_rt;

  logic                   load_use;
  logic                   early_dep;
  logic                   step_ok;

  id_ex_t                 id_ex_d;
  id_ex_t                 id_ex_q;

  assign opcode      = i_instr[31:26];
  assign rs_addr     = i_instr[25:21];
  assign rt_addr     = i_instr[20:16];
  assign rd_addr     = i_instr[15:11];
  assign funct       = i_instr[5:0];
  assign op_class    = classify(opcode);
  assign is_jump_reg = (op_class == CLS_RTYPE) && (funct == FUNCT_JR || funct == FUNCT_JALR);

  assign o_inm_i = i_instr[NB_INM_I-1:0];
  assign o_inm_j = i_instr[NB_INM_J-1:0];
  assign o_rs    = rs_val;

  register_file #(
    .NB_REG      (NB_REG),
    .N_REGS      (N_REGS),
    .NB_REG_ADDR (NB_REG_ADDR)
  ) u_register_file (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_we      (i_wb_we && i_valid),
    .i_waddr   (i_wb_addr),
    .i_wdata   (i_wb_data),
    .i_raddr_a (rs_addr),
    .i_raddr_b (rt_addr),
    .o_rdata_a (rs_val),
    .o_rdata_b (rt_val)
  );

  // Logical ops zero-extend their immediate, everything else sign-extends.
  always_comb begin
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      inm_ext = {{(NB_REG-NB_INM_I){1'b0}}, o_inm_i};
    else
      inm_ext = {{(NB_REG-NB_INM_I){o_inm_i[NB_INM_I-1]}}, o_inm_i};
  end

  // Control decode and which source registers the instruction consumes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    ctrl_d    = '0;
    rd_dest_d = '0;
    reads_rt  = 1'b0;
    early_rs  = 1'b0;
    early_rt  = 1'b0;
    unique case (op_class)
      CLS_RTYPE: begin
        reads_rt = 1'b1;
        early_rs = is_jump_reg;
        if (funct != FUNCT_JR) begin
          ctrl_d.regwrite = 1'b1;
          ctrl_d.link     = (funct == FUNCT_JALR);
          rd_dest_d       = rd_addr;
        end
      end
      CLS_JUMP: begin
        if (opcode == OP_JAL) begin
          ctrl_d.regwrite = 1'b1;
          ctrl_d.link     = 1'b1;
          rd_dest_d       = REG_RA;
        end
      end
      CLS_BRANCH: begin
        reads_rt = 1'b1;
        early_rs = 1'b1;
        early_rt = 1'b1;
      end
      CLS_ALUI: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        rd_dest_d       = rt_addr;
      end
      CLS_LOAD: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.memread  = 1'b1;
        ctrl_d.memtoreg = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        rd_dest_d       = rt_addr;
      end
      CLS_STORE: begin
        reads_rt        = 1'b1;
        ctrl_d.memwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall on load-use, or when an early-resolved branch/jump needs a value still in flight.
  always_comb begin
    load_use  = i_ex_memread && (i_ex_dest != '0) &&
                ((i_ex_dest == rs_addr) || (reads_rt && i_ex_dest == rt_addr));
    early_dep = 1'b0;
    if (i_ex_regwrite && i_ex_dest != '0)
      early_dep = (early_rs && i_ex_dest == rs_addr) || (early_rt && i_ex_dest == rt_addr);
    if (i_mem_regwrite && i_mem_dest != '0)
      early_dep = early_dep ||
                  (early_rs && i_mem_dest == rs_addr) || (early_rt && i_mem_dest == rt_addr);
    o_hazard = load_use || early_dep;
  end

  // Redirect requests to fetch, suppressed while stalled or not stepping.
  always_comb begin
    step_ok    = i_valid && !o_hazard;
    o_branch   = step_ok && (((opcode == OP_BEQ) && (rs_val == rt_val)) ||
                             ((opcode == OP_BNE) && (rs_val != rt_val)));
    o_jump_inm = step_ok && (op_class == CLS_JUMP);
    o_jump_rs  = step_ok && is_jump_reg;
  end

  // Next ID/EX contents; a stall injects a bubble by dropping controls and destination.
  always_comb begin
    id_ex_d           = '0;
    id_ex_d.rs_data   = rs_val;
    id_ex_d.rt_data   = rt_val;
    id_ex_d.inm       = inm_ext;
    id_ex_d.link_addr = i_pc + NB_REG'(4);
    id_ex_d.rs_addr   = rs_addr;
    id_ex_d.rt_addr   = rt_addr;
    id_ex_d.opcode    = opcode;
    id_ex_d.funct     = funct;
    id_ex_d.ctrl      = o_hazard ? '0 : ctrl_d;
    id_ex_d.rd_dest   = o_hazard ? '0 : rd_dest_d;
  end

  // ID/EX pipeline register, advancing only on a global step.
  always_ff @(posedge i_clock or negedge i_reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
    if (!i_reset)     id_ex_q <= '0;
    else if (i_valid) id_ex_q <= id_ex_d;
  end

  assign o_rs_data   = id_ex_q.rs_data;
  assign o_rt_data   = id_ex_q.rt_data;
  assign o_inm       = id_ex_q.inm;
  assign o_link_addr = id_ex_q.link_addr;
  assign o_rs_addr   = id_ex_q.rs_addr;
  assign o_rt_addr   = id_ex_q.rt_addr;
  assign o_rd_dest   = id_ex_q.rd_dest;
  assign o_opcode    = id_ex_q.opcode;
  assign o_funct     = id_ex_q.funct;
  assign o_regwrite  = id_ex_q.ctrl.regwrite;
  assign o_memread   = id_ex_q.ctrl.memread;
  assign o_memwrite  = id_ex_q.ctrl.memwrite;
  assign o_memtoreg  = id_ex_q.ctrl.memtoreg;
  assign o_alusrc    = id_ex_q.ctrl.alusrc;
  assign o_link      = id_ex_q.ctrl.link;

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameters SHALL be: NB_REG=32 (data width); NB_INSTR=32 (instruction width); N_REGS=32 (register count); NB_REG_ADDR=5 (register address width); NB_INM_I=16 (I-type immediate width); NB_INM_J=26 (J-type target width).
REQ-002 Ports, in order (name, direction, width, meaning):
- i_clock, in, 1, clock.
- i_reset, in, 1, asynchronous active-low reset.
- i_valid, in, 1, global step enable.
- i_instr, in, 32, fetched instruction from the fetch stage.
- i_pc, in, 32, fetch-stage PC+4.
- i_wb_we, in, 1, write-back write enable.
- i_wb_addr, in, 5, write-back register address.
- i_wb_data, in, 32, write-back data.
- i_ex_regwrite, in, 1, EX-stage instruction writes a register.
- i_ex_memread, in, 1, EX-stage instruction is a load.
- i_ex_dest, in, 5, EX-stage destination register.
- i_mem_regwrite, in, 1, MEM-stage instruction writes a register.
- i_mem_dest, in, 5, MEM-stage destination register.
- o_inm_i, out, 16, instr[15:0], to fetch.
- o_inm_j, out, 26, instr[25:0], to fetch.
- o_rs, out, 32, rs read data, to fetch.
- o_branch, o_jump_inm, o_jump_rs, o_hazard, out, 1 each, fetch-stage controls.
- o_rs_data, o_rt_data, o_inm, out, 32 each, registered operands.
- o_rs_addr, o_rt_addr, o_rd_dest, out, 5 each, registered register fields.
- o_opcode, o_funct, out, 6 each, registered.
- o_link_addr, out, 32, registered.
- o_regwrite, o_memread, o_memwrite, o_memtoreg, o_alusrc, o_link, out, 1 each, registered controls.

Function
REQ-003 Register file SHALL hold 32x32 entries; r0 SHALL read 0 and ignore writes.
REQ-004 Write SHALL occur on posedge when i_wb_we & i_valid & i_wb_addr!=0.
REQ-005 Reads of rs=instr[25:21] and rt=instr[20:16] SHALL be combinational, with write-first bypass: a read of i_wb_addr while a write is enabled returns i_wb_data.
REQ-006 o_hazard SHALL be combinational and assert on either condition:
- Load-use: i_ex_memread & i_ex_dest!=0 & (i_ex_dest==rs | (i_ex_dest==rt & instruction reads rt)).
- Branch/JR/JALR dependency: the instruction reads a register that equals i_ex_dest with i_ex_regwrite, or i_mem_dest with i_mem_regwrite, with the matching dest !=0.
REQ-007 o_branch SHALL be 1 for BEQ (000100) when rs==rt and for BNE (000101) when rs!=rt, compared on bypassed read data.
REQ-008 o_jump_inm SHALL be 1 for J (000010) and JAL (000011).
REQ-009 o_jump_rs SHALL be 1 for R-type (000000) with funct JR (001000) or JALR (001001).
REQ-010 o_branch, o_jump_inm and o_jump_rs SHALL be mutually exclusive, and all SHALL be 0 when o_hazard=1 or i_valid=0.
REQ-011 The delay-slot instruction after a taken branch or jump SHALL execute; no flush.
REQ-012 o_inm SHALL be zero-extended for ANDI/ORI/XORI (001100/001101/001110) and sign-extended otherwise.
REQ-013 o_rd_dest SHALL be:
- rd for R-type and JALR;
- rt for ALU-immediate (001xxx) and loads;
- 31 for JAL;
- 0 when o_regwrite=0.
REQ-014 Control outputs SHALL decode as:
- o_regwrite: R-type except JR, 001xxx, 100xxx, JAL.
- o_memread and o_memtoreg: 100xxx.
- o_memwrite: 101xxx.
- o_alusrc: 001xxx, 100xxx, 101xxx.
- o_link: JAL, JALR.
- o_link_addr: i_pc+4.
REQ-015 ID/EX register SHALL update on posedge only when i_valid=1.
REQ-016 With o_hazard=1, the register SHALL load a bubble: all control bits 0, o_rd_dest=0, data fields don't-care. Otherwise it loads the decoded values; latency is 1 cycle.
REQ-017 With i_valid=0, all registered state and the register file SHALL hold.
REQ-018 Unknown opcodes SHALL decode as NOP: all controls 0.

Reset
REQ-019 i_reset=0 SHALL asynchronously clear all register-file entries and every registered output to 0.
REQ-020 Reset release SHALL be synchronous-safe: the first update occurs on the first posedge with i_reset=1 and i_valid=1.

Structure
REQ-021 Opcode and funct constants and width parameters SHALL live in a shared package, mips_pkg.
REQ-022 The register file SHALL be the sub-module register_file, with 2 read ports, 1 write port and bypass.

Verification
REQ-023 Write r5=0x1234 via WB while decoding ADD using rs=r5 in the same cycle -> o_rs_data=0x1234 on the next edge.
REQ-024 LW r3 in EX (i_ex_memread=1, i_ex_dest=3), ADD r4,r3,r1 in ID -> o_hazard=1; the next edge loads a bubble (o_regwrite=0); the instruction decodes once the load leaves EX.
REQ-025 BEQ r1,r2 with r1=r2=7 -> o_branch=1; with r2=8 -> o_branch=0; BNE gives the inverse.
REQ-026 JAL 0x100 with i_pc=0x40 -> o_jump_inm=1, o_inm_j=0x100; next edge o_rd_dest=31, o_link=1, o_link_addr=0x44.
REQ-027 JR r9 while i_mem_regwrite=1 and i_mem_dest=9 -> o_hazard=1 and o_jump_rs=0; when the stall clears -> o_jump_rs=1 and o_rs equals r9.
REQ-028 Drop i_reset mid-stream -> all outputs 0 immediately; a write to r0 leaves r0 reading 0.
